// File: rtl/ffe_pkg.sv
// rtl/ffe_pkg.sv - shared state encoding and width helper for the FFE MAC sequencer
package ffe_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_MAC   = 2'd2;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ffe_rise_det.sv
// rtl/ffe_rise_det.sv - rising-edge detector whose history resets high so a held level is not an edge
module ffe_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level_i;
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/ffe_mac_sequencer.sv
// rtl/ffe_mac_sequencer.sv - control FSM for a time-multiplexed FFE: one MAC cycle per tap per sample
module ffe_mac_sequencer
  import ffe_pkg::*;
#(
  parameter int NUM_TAPS = 3,
  parameter int IDX_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_in,
  input  logic             cfg_valid,
  input  logic [IDX_W-1:0] cfg_addr,
  output logic             cfg_ready,
  output logic             coef_we,
  output logic [IDX_W-1:0] coef_waddr,
  output logic             shift_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic [IDX_W-1:0] tap_sel,
  output logic             out_load,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
);

  if (IDX_W < idx_width(NUM_TAPS)) begin : g_bad_idx_w
    $error("IDX_W too narrow for NUM_TAPS");
  end

  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);
  localparam logic [IDX_W:0]   TAP_CNT  = (IDX_W + 1)'(NUM_TAPS);

  logic             start;
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] tap_q, tap_d;
  logic             out_load_q, out_load_d;
  logic             data_valid_q;
  logic             overrun_q, overrun_d;

  ffe_rise_det u_rise_det (
    .clk     (clk),
    .rst     (rst),
    .level_i (load_in),
    .rise_o  (start)
  );

  // The last MAC cycle may accept the next start so samples can run back-to-back.
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    out_load_d = 1'b0;
    overrun_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        state_d   = ST_MAC;
        tap_d     = '0;
        overrun_d = start;
      end
      ST_MAC: begin
        if (tap_q == LAST_TAP) begin
          tap_d      = '0;
          out_load_d = 1'b1;
          state_d    = start ? ST_SHIFT : ST_IDLE;
        end else begin
          tap_d     = tap_q + 1'b1;
          overrun_d = start;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      out_load_q   <= 1'b0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      out_load_q   <= out_load_d;
      data_valid_q <= out_load_q;
      overrun_q    <= overrun_d;
    end
  end

  assign shift_en   = (state_q == ST_SHIFT);
  assign acc_clr    = (state_q == ST_SHIFT);
  assign acc_en     = (state_q == ST_MAC);
  assign tap_sel    = tap_q;
  assign busy       = (state_q != ST_IDLE);
  assign out_load   = out_load_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;

  // Writes only land between samples; a same-cycle start takes priority.
  assign cfg_ready  = (state_q == ST_IDLE) & ~start;
  assign coef_we    = cfg_valid & cfg_ready & ({1'b0, cfg_addr} < TAP_CNT);
  assign coef_waddr = cfg_addr;

endmodule

// File: tb/tb_ffe_mac_sequencer.sv
// tb/tb_ffe_mac_sequencer.sv - randomized self-checking bench against a sample-timeline reference model
`timescale 1ns/1ps
module tb_ffe_mac_sequencer;

  localparam int N     = 3;
  localparam int W     = 2;
  localparam int DEPTH = 8192;

  logic         clk = 1'b0;
  logic         rst, load_in, cfg_valid;
  logic [W-1:0] cfg_addr;
  logic         cfg_ready, coef_we, shift_en, acc_clr, acc_en, out_load, data_valid, busy, overrun;
  logic [W-1:0] coef_waddr, tap_sel;

  ffe_mac_sequencer #(.NUM_TAPS(N), .IDX_W(W)) dut (
    .clk(clk), .rst(rst), .load_in(load_in), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
    .cfg_ready(cfg_ready), .coef_we(coef_we), .coef_waddr(coef_waddr), .shift_en(shift_en),
    .acc_clr(acc_clr), .acc_en(acc_en), .tap_sel(tap_sel), .out_load(out_load),
    .data_valid(data_valid), .busy(busy), .overrun(overrun)
  );

  always #125 clk = ~clk;

  // Timeline of what each cycle is expected to show, filled when a sample is accepted.
  bit m_shift [DEPTH];
  bit m_mac   [DEPTH];
  int m_tap   [DEPTH];
  bit m_ol    [DEPTH];
  bit m_dv    [DEPTH];
  bit m_ov    [DEPTH];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit load_prev = 1'b1;
  bit acc;
  int cnt_dv = 0, cnt_ov = 0, cnt_we = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit l);
    bit st, occ, rdy, we;
    rst     = r;
    load_in = l;
    st   = l & ~load_prev;
    occ  = m_shift[cyc] | m_mac[cyc];
    rdy  = ~occ & ~st;
    we   = cfg_valid & rdy & (int'(cfg_addr) < N);
    acc  = cfg_valid & rdy;
    if (r) begin
      for (int i = cyc + 1; i <= cyc + N + 4; i++) begin
        m_shift[i] = 0; m_mac[i] = 0; m_tap[i] = 0; m_ol[i] = 0; m_dv[i] = 0; m_ov[i] = 0;
      end
      load_prev = 1'b1;
    end else begin
      load_prev = l;
      if (st) begin
        // A sample occupies N+1 cycles; a new one fits only if the next cycle is free.
        if (m_shift[cyc + 1] || m_mac[cyc + 1]) begin
          m_ov[cyc + 1] = 1;
        end else begin
          m_shift[cyc + 1] = 1;
          for (int k = 0; k < N; k++) begin
            m_mac[cyc + 2 + k] = 1;
            m_tap[cyc + 2 + k] = k;
          end
          m_ol[cyc + N + 2] = 1;
          m_dv[cyc + N + 3] = 1;
        end
      end
    end
    @(negedge clk);
    chk("shift_en",   shift_en,   m_shift[cyc]);
    chk("acc_clr",    acc_clr,    m_shift[cyc]);
    chk("acc_en",     acc_en,     m_mac[cyc]);
    chk("tap_sel",    tap_sel,    m_mac[cyc] ? m_tap[cyc] : 0);
    chk("busy",       busy,       occ);
    chk("out_load",   out_load,   m_ol[cyc]);
    chk("data_valid", data_valid, m_dv[cyc]);
    chk("overrun",    overrun,    m_ov[cyc]);
    chk("cfg_ready",  cfg_ready,  rdy);
    chk("coef_we",    coef_we,    we);
    chk("coef_waddr", coef_waddr, cfg_addr);
    cnt_dv += int'(data_valid === 1'b1);
    cnt_ov += int'(overrun === 1'b1);
    cnt_we += int'(coef_we === 1'b1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic hold_cfg(input logic [W-1:0] a, input bit first_load);
    int budget;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    step(0, first_load);
    budget = 0;
    while (!acc && budget < 50) begin
      step(0, 0);
      budget++;
    end
    chk("cfg_stall_bound", budget < 50, 1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int b_dv, b_ov, b_we;
    bit l;
    rst = 1; load_in = 1; cfg_valid = 0; cfg_addr = '0;
    @(posedge clk);
    #1;

    // Reset with load held high, then no start until a fresh rising edge.
    step(1, 1); step(1, 1);
    b_dv = cnt_dv;
    step(0, 1); step(0, 1); step(0, 1);
    idle(6);
    chk("no_start_after_reset", cnt_dv - b_dv, 0);

    // Single sample.
    b_dv = cnt_dv;
    step(0, 1); step(0, 0);
    idle(8);
    chk("single_dv", cnt_dv - b_dv, 1);

    // Back-to-back every 4 clk.
    b_dv = cnt_dv; b_ov = cnt_ov;
    for (int i = 0; i < 32; i++) begin
      step(0, 1); step(0, 0); step(0, 0); step(0, 0);
    end
    idle(8);
    chk("b2b_dv", cnt_dv - b_dv, 32);
    chk("b2b_ov", cnt_ov - b_ov, 0);

    // Second edge two cycles after the first is dropped.
    b_dv = cnt_dv; b_ov = cnt_ov;
    step(0, 1); step(0, 0); step(0, 1); step(0, 0);
    idle(8);
    chk("overrun_dv", cnt_dv - b_dv, 1);
    chk("overrun_ov", cnt_ov - b_ov, 1);

    // Wide strobe spanning two edges.
    b_dv = cnt_dv;
    step(0, 1); step(0, 1); step(0, 0);
    idle(8);
    chk("wide_dv", cnt_dv - b_dv, 1);

    // Config write requested during MAC stalls until idle.
    b_we = cnt_we;
    step(0, 1); step(0, 0); step(0, 0);
    hold_cfg(2'd1, 1'b0);
    idle(4);
    chk("cfg_mac_we", cnt_we - b_we, 1);

    // Start and config in the same cycle: start wins.
    b_we = cnt_we; b_dv = cnt_dv;
    hold_cfg(2'd2, 1'b1);
    idle(8);
    chk("cfg_tie_we", cnt_we - b_we, 1);
    chk("cfg_tie_dv", cnt_dv - b_dv, 1);

    // Out-of-range address is handshaken but never written.
    b_we = cnt_we;
    hold_cfg(2'd3, 1'b0);
    idle(2);
    chk("cfg_oob_we", cnt_we - b_we, 0);

    // Reset in the third cycle of a sample abandons it.
    b_dv = cnt_dv;
    step(0, 1); step(0, 1); step(0, 1); step(1, 0);
    idle(8);
    chk("reset_mid_dv", cnt_dv - b_dv, 0);

    // Randomized traffic.
    l = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!cfg_valid || acc) begin
        cfg_valid = ($urandom_range(0, 2) == 0);
        cfg_addr  = W'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) l = ~l;
      step($urandom_range(0, 199) == 0, l);
    end
    cfg_valid = 1'b0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
